// File: rtl/ws_pixel_stream.sv
// One-wire NRZ LED serialiser (WS2812/SK6812 class) fed through a small FIFO of
// pixel words and latch commands; MSB of each pixel goes out first.
module ws_pixel_stream #(
  parameter int BPP          = 24,
  parameter int DEPTH        = 8,
  parameter int TBIT         = 20,
  parameter int T0H          = 6,
  parameter int T1H          = 13,
  parameter int RESET_CYCLES = 1280,
  parameter bit AUTO_LATCH   = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [BPP-1:0]         in_data,
  input  logic                   in_latch,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   dout,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level
);
  // Handshake: an entry moves on every rising edge where in_valid && in_ready;
  // in_valid is ignored while in_ready is low.
  localparam int AW   = $clog2(DEPTH);
  localparam int TMAX = (TBIT > RESET_CYCLES) ? TBIT : RESET_CYCLES;
  localparam int TW   = $clog2(TMAX);
  localparam int BW   = $clog2(BPP);
  localparam logic [TW-1:0] TBIT_LD = TW'(TBIT - 1);
  localparam logic [TW-1:0] RST_LD  = TW'(RESET_CYCLES - 1);
  localparam logic [TW-1:0] T0_THR  = TW'(TBIT - T0H);
  localparam logic [TW-1:0] T1_THR  = TW'(TBIT - T1H);

  typedef enum logic [1:0] {IDLE, BITS, LATCH} state_t;

  logic [BPP:0]    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            push, pop, load;
  logic [BPP:0]    head;

  state_t          state_q, state_d;
  logic [BPP-1:0]  shift_q, shift_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic            dout_q, dout_d;

  assign in_ready = (count_q != (AW+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign head     = mem_q[rd_ptr_q];
  assign level    = count_q;
  assign dout     = dout_q;
  assign busy     = (count_q != '0) || (state_q != IDLE);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_d   = bit_q;
    tick_d  = tick_q;
    load    = 1'b0;
    case (state_q)
      IDLE: load = 1'b1;
      BITS: begin
        if (tick_q != '0) begin
          tick_d = tick_q - TW'(1);
        end else if (bit_q != '0) begin
          shift_d = shift_q << 1;
          bit_d   = bit_q - BW'(1);
          tick_d  = TBIT_LD;
        end else begin
          load    = 1'b1;
          state_d = AUTO_LATCH ? LATCH : IDLE;
          tick_d  = RST_LD;
        end
      end
      LATCH: begin
        if (tick_q != '0) begin
          tick_d = tick_q - TW'(1);
        end else begin
          load    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // A queued entry always overrides the fall-back state so slots stay gapless.
    pop = load && (count_q != '0);
    if (pop) begin
      if (head[BPP]) begin
        state_d = LATCH;
        tick_d  = RST_LD;
      end else begin
        state_d = BITS;
        shift_d = head[BPP-1:0];
        bit_d   = BW'(BPP - 1);
        tick_d  = TBIT_LD;
      end
    end
    // Line is high during the leading T0H/T1H clocks of each bit slot.
    dout_d = (state_d == BITS) && (tick_d >= (shift_d[BPP-1] ? T1_THR : T0_THR));
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_latch, in_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      tick_q   <= '0;
      dout_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      tick_q   <= tick_d;
      dout_q   <= dout_d;
    end
  end
endmodule

// File: doc/ws_pixel_stream.md
# ws_pixel_stream

Parametrised successor of the single-pixel serial LED driver: accepts a stream of pixel words and latch commands through a valid/ready port, buffers them in an internal FIFO, and serialises them onto a one-wire NRZ LED data line (WS2812/SK6812 class) with configurable bit timing and pixel width. Sits between the frame/pattern generator and the LED strip pad. Supports gapless back-to-back pixels, RGBW (32-bit) pixels, and optional automatic latch insertion on underrun.

## Interface
- BPP, 24: bits per pixel word (24 RGB, 32 RGBW); legal 8..32.
- DEPTH, 8: FIFO entries; power of two, ≥2.
- TBIT, 20: clocks per data bit (1.25 µs at 16 MHz).
- T0H, 6: high clocks for a 0 bit; 1 ≤ T0H < T1H.
- T1H, 13: high clocks for a 1 bit; T1H < TBIT.
- RESET_CYCLES, 1280: low clocks for a latch (80 µs at 16 MHz); ≥2.
- AUTO_LATCH, 1: 1 = insert latch automatically when the FIFO runs empty after a pixel.
- clk  in  1  sole clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  BPP  pixel word, MSB transmitted first; ignored when in_latch=1.
- in_latch  in  1  1 = entry is a latch command rather than a pixel.
- in_valid  in  1  entry presented.
- in_ready  out  1  FIFO not full; entry accepted on edge where in_valid && in_ready.
- dout  out  1  serial LED data, registered.
- busy  out  1  FIFO non-empty or engine not IDLE.
- level  out  clog2(DEPTH)+1  FIFO occupancy, registered.

## Operation
- FIFO entry = {in_latch, in_data}. Push on in_valid && in_ready; push while full is impossible (in_ready=0), in_valid ignored. Simultaneous push and pop: level unchanged.
- Engine states: IDLE, BITS, LATCH.
- IDLE: dout=0. If FIFO non-empty, pop head: pixel -> BITS (load shift register, bit counter=BPP-1, tick=TBIT-1); latch -> LATCH (tick=RESET_CYCLES-1).
- BITS: per bit, dout=1 for first T0H or T1H clocks (by current MSB), 0 for remaining clocks of TBIT. At tick 0: if bits remain, shift left, next bit; else end of pixel.
- End of pixel: FIFO non-empty -> pop head on same edge, next pixel's first bit or latch begins with no gap. FIFO empty -> LATCH if AUTO_LATCH=1, else IDLE.
- LATCH: dout=0 for exactly RESET_CYCLES clocks. At completion: FIFO non-empty -> pop head same edge; else IDLE. Latch is not abortable; entries arriving during it wait.
- Consecutive latches (explicit after auto, or latch-latch) are each executed in full; no merging.
- AUTO_LATCH=0 and FIFO empty mid-frame: line idles low in IDLE; caller is responsible for not underrunning beyond strip tolerance.
- Counters: tick width clog2(max(TBIT,RESET_CYCLES)); no wrap, reloaded on every transition.

## Timing
- Reset (rst_n low, async): dout=0, state IDLE, FIFO empty, level=0, busy=0, in_ready=1 after release. Reset mid-bit truncates output immediately; no partial completion.
- Latency: entry accepted at edge E0 into empty FIFO with engine IDLE -> popped at edge E0+1; dout high from E0+1 through E0+1+T(0|1)H.
- Bit period exactly TBIT clocks; pixel exactly BPP*TBIT clocks; successive queued pixels have zero idle clocks between them.
- Latch duration exactly RESET_CYCLES clocks of dout=0 beyond the last bit's low tail.
- level and in_ready update on the edge after push/pop; in_ready = (level != DEPTH).
- busy falls on the edge the engine enters IDLE with FIFO empty.

## Test plan
- Single pixel 0xA50000 (BPP=24, AUTO_LATCH=0): dout high 13,6,13,6,6,13,6,13 clocks in first 8 bit slots of 20, then 16 slots of 6 high; IDLE after 480 clocks, busy=0.
- Three pixels pushed back-to-back then latch: 1440 contiguous clocks of bit slots with no gaps, then exactly 1280 low clocks, then busy=0.
- Fill FIFO (DEPTH=8) while engine holds first pixel: in_ready=0 at level 8, ninth push refused; entries drain in order with correct data.
- AUTO_LATCH=1, one pixel then push second pixel 100 clocks into auto-latch: second pixel starts exactly 1280 clocks after first pixel end.
- BPP=32, T0H=4, T1H=10, TBIT=16: pixel 0x80000001 gives 10-high first slot, 4-high slots 2..31, 10-high slot 32; total 512 clocks.
- Assert rst_n low mid-bit with FIFO level 3: dout=0 immediately, level=0, in_ready=1 after release; next pushed pixel transmits cleanly from bit 0.
